// File: rtl/regfile_sb.sv
// Parametrised integer register file with hardwired-zero x0, N read ports and a pending-write scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  output logic [NUM_REGS-1:0]    busy_vec
);

  logic [XLEN-1:0]     regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] busy;
  logic [AW-1:0]       rd_idx [NUM_RD];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_en && wr_addr == AW'(i)) begin
          regs[i] <= wr_data;
        end
        // A reservation landing on the register being written back wins: the new producer is still in flight.
        if (rsv_en && rsv_addr == AW'(i)) begin
          busy[i] <= 1'b1;
        end else if (wr_en && wr_addr == AW'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_idx[k] = rd_addr[k*AW +: AW];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (rd_idx[k] == AW'(i)) begin
          rd_data[k*XLEN +: XLEN] = regs[i];
        end
      end
      rd_busy[k] = busy[rd_idx[k]];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr != '0 && rd_idx[k] == wr_addr) begin
        rd_data[k*XLEN +: XLEN] = wr_data;
        if (!(rsv_en && rsv_addr == wr_addr)) begin
          rd_busy[k] = 1'b0;
        end
      end
`endif
    end
  end

  assign busy_vec = busy;

endmodule
